// File: rtl/exec_pkg.sv
// Shared definitions for the execute-stage condition/output buffer and
// anything else that evaluates condition codes against NZCV.
package exec_pkg;

    localparam int ENTRY_DATA_W = 32;
    localparam int ENTRY_RD_W   = 4;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic [ENTRY_DATA_W-1:0] result;
        logic [ENTRY_RD_W-1:0]   rd;
        logic                    wr_en;
        logic                    executed;
    } entry_t;

endpackage

// File: rtl/exec_cond_stage_cond_eval.sv
// Combinational condition-code check against an NZCV flag vector.
// Kept standalone so the branch unit can reuse it.
module cond_eval
    import exec_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       pass_o
);

    logic n, z, c, v;

    assign n = flags_i[FLAG_N];
    assign z = flags_i[FLAG_Z];
    assign c = flags_i[FLAG_C];
    assign v = flags_i[FLAG_V];

    // Decode the condition code into a pass/fail decision
    always_comb begin
        pass_o = 1'b0;
        case (cond_i)
            COND_EQ: pass_o = z;
            COND_NE: pass_o = !z;
            COND_CS: pass_o = c;
            COND_CC: pass_o = !c;
            COND_MI: pass_o = n;
            COND_PL: pass_o = !n;
            COND_VS: pass_o = v;
            COND_VC: pass_o = !v;
            COND_HI: pass_o = c && !z;
            COND_LS: pass_o = !c || z;
            COND_GE: pass_o = (n == v);
            COND_LT: pass_o = (n != v);
            COND_GT: pass_o = !z && (n == v);
            COND_LE: pass_o = z || (n != v);
            COND_AL: pass_o = 1'b1;
            default: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_cond_stage.sv
// Execute-stage output buffer: holds the committed NZCV flags, gates write
// enable and flag update on each instruction's condition, and hands results
// to writeback through a two-entry skid buffer.
//
// state | meaning
// EMPTY | no entries held
// ONE   | output register holds an entry
// TWO   | output and skid registers both hold entries (in_ready low)
module exec_cond_stage
    import exec_pkg::*;
#(
    parameter int DATA_W = ENTRY_DATA_W,
    parameter int RD_W   = ENTRY_RD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_n,
    input  logic              in_z,
    input  logic              in_c,
    input  logic              in_v,
    input  logic [3:0]        in_cond,
    input  logic              in_set_flags,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_wr_en,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_wr_en,
    output logic              out_executed,
    output logic [3:0]        flags
);

    buf_state_e state_q, state_d;
    entry_t     out_q, out_d;
    entry_t     skid_q, skid_d;
    entry_t     new_entry;
    logic [3:0] flags_q, flags_d;
    logic       pass;
    logic       accept;
    logic       pop;

    // in_ready comes from the state register only, so no input-to-ready path
    assign in_ready  = !rst && (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    // Condition is checked against flags before this instruction's own update
    cond_eval u_cond_eval (
        .cond_i  (in_cond),
        .flags_i (flags_q),
        .pass_o  (pass)
    );

    // Build the buffer entry for the incoming instruction
    always_comb begin
        new_entry.result   = in_result;
        new_entry.rd       = in_rd;
        new_entry.wr_en    = in_wr_en && pass;
        new_entry.executed = pass;
    end

    // Flags commit at the accept edge; flush never rolls them back
    always_comb begin
        flags_d = flags_q;
        if (accept && pass && in_set_flags) begin
            flags_d = {in_n, in_z, in_c, in_v};
        end
    end

    // Skid buffer next-state and data movement
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        out_d   = new_entry;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        out_d = new_entry;
                    end else if (accept) begin
                        state_d = TWO;
                        skid_d  = new_entry;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d = ONE;
                        out_d   = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State, buffer and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            flags_q <= flags_d;
        end
    end

    assign out_result   = out_q.result;
    assign out_rd       = out_q.rd;
    assign out_wr_en    = out_q.wr_en;
    assign out_executed = out_q.executed;
    assign flags        = flags_q;

endmodule

// File: tb/tb_exec_cond_stage.sv
// Bench for exec_cond_stage: condition table plus hand-written stall,
// flush and reset sequences, with a scoreboard queue of expected entries.
module tb_exec_cond_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_n, in_z, in_c, in_v;
    logic [3:0]  in_cond;
    logic        in_set_flags;
    logic [3:0]  in_rd;
    logic        in_wr_en;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_rd;
    logic        out_wr_en;
    logic        out_executed;
    logic [3:0]  flags;

    exec_cond_stage #(.DATA_W(32), .RD_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_n         (in_n),
        .in_z         (in_z),
        .in_c         (in_c),
        .in_v         (in_v),
        .in_cond      (in_cond),
        .in_set_flags (in_set_flags),
        .in_rd        (in_rd),
        .in_wr_en     (in_wr_en),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_rd       (out_rd),
        .out_wr_en    (out_wr_en),
        .out_executed (out_executed),
        .flags        (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] result;
        logic [3:0]  rd;
        logic        wr_en;
        logic        exec;
    } exp_t;

    typedef struct {
        logic [3:0] nzcv;
        logic [3:0] cond;
        logic       exp_exec;
    } vec_t;

    exp_t       sb[$];
    logic [3:0] mflags;
    int         cur_exp;
    int         n_tests;
    int         n_fail;
    vec_t       vecs[22];

    // Reference condition evaluator: base test on cond[3:1], cond[0] inverts
    function automatic logic model_cond(logic [3:0] c, logic [3:0] f);
        logic n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cf;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cf && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle, entered and left at a falling edge
    task automatic tick();
        exp_t e;
        bit   acc, pop, pass;
        check("in_ready", in_ready, (sb.size() < 2));
        check("out_valid", out_valid, (sb.size() != 0));
        pop = out_valid && out_ready;
        acc = in_valid && in_ready && !flush;
        if (pop) begin
            if (sb.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_pop: got rd %0h expected no entry", out_rd);
            end else begin
                e = sb.pop_front();
                check("out_result",   out_result,   e.result);
                check("out_rd",       out_rd,       e.rd);
                check("out_wr_en",    out_wr_en,    e.wr_en);
                check("out_executed", out_executed, e.exec);
            end
        end
        if (flush) sb.delete();
        if (acc) begin
            pass = (cur_exp < 0) ? model_cond(in_cond, mflags) : cur_exp[0];
            e.result = in_result;
            e.rd     = in_rd;
            e.wr_en  = in_wr_en && pass;
            e.exec   = pass;
            sb.push_back(e);
            if (pass && in_set_flags) mflags = {in_n, in_z, in_c, in_v};
        end
        @(posedge clk);
        @(negedge clk);
        check("flags", flags, mflags);
    endtask

    task automatic send(logic [31:0] res, logic [3:0] rd, logic wr, logic [3:0] cond,
                        logic setf, logic [3:0] nzcv, int ex);
        bit done;
        bit was;
        done = 0;
        in_valid = 1'b1; in_result = res; in_rd = rd; in_wr_en = wr; in_cond = cond;
        in_set_flags = setf; {in_n, in_z, in_c, in_v} = nzcv;
        cur_exp = ex;
        for (int k = 0; k < 20; k++) begin
            was = in_ready && !flush;
            tick();
            if (was) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: got no accept expected accept within 20 cycles");
        end
        in_valid = 1'b0;
        cur_exp  = -1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (sb.size() == 0 && !out_valid) break;
            tick();
        end
        check("drain_out_valid", out_valid, 0);
        if (sb.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain_lost: got %0d entries outstanding expected 0", sb.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{4'b0100, 4'd0,  1'b1};
        vecs[1]  = '{4'b0000, 4'd0,  1'b0};
        vecs[2]  = '{4'b0000, 4'd1,  1'b1};
        vecs[3]  = '{4'b0010, 4'd2,  1'b1};
        vecs[4]  = '{4'b0010, 4'd3,  1'b0};
        vecs[5]  = '{4'b1000, 4'd4,  1'b1};
        vecs[6]  = '{4'b1000, 4'd5,  1'b0};
        vecs[7]  = '{4'b0001, 4'd6,  1'b1};
        vecs[8]  = '{4'b0001, 4'd7,  1'b0};
        vecs[9]  = '{4'b0010, 4'd8,  1'b1};
        vecs[10] = '{4'b0110, 4'd8,  1'b0};
        vecs[11] = '{4'b0110, 4'd9,  1'b1};
        vecs[12] = '{4'b1001, 4'd10, 1'b1};
        vecs[13] = '{4'b1000, 4'd10, 1'b0};
        vecs[14] = '{4'b1000, 4'd11, 1'b1};
        vecs[15] = '{4'b1000, 4'd12, 1'b0};
        vecs[16] = '{4'b1001, 4'd12, 1'b1};
        vecs[17] = '{4'b0100, 4'd13, 1'b1};
        vecs[18] = '{4'b0000, 4'd13, 1'b0};
        vecs[19] = '{4'b0000, 4'd14, 1'b1};
        vecs[20] = '{4'b1111, 4'd15, 1'b0};
        vecs[21] = '{4'b0000, 4'd15, 1'b0};

        n_tests = 0; n_fail = 0; cur_exp = -1; mflags = 4'b0000;
        rst = 1'b1; in_valid = 1'b0; in_result = '0; {in_n, in_z, in_c, in_v} = 4'b0000;
        in_cond = 4'd14; in_set_flags = 1'b0; in_rd = '0; in_wr_en = 1'b0;
        flush = 1'b0; out_ready = 1'b1;

        // Reset state
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready",  in_ready,  0);
        check("rst_flags",     flags,     0);
        check("rst_out_result", out_result, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        @(negedge clk);

        // First instruction: AL with flag update
        send(32'h0, 4'd3, 1'b1, 4'd14, 1'b1, 4'b0100, -1);
        check("t1_out_valid",    out_valid,    1);
        check("t1_out_executed", out_executed, 1);
        check("t1_out_wr_en",    out_wr_en,    1);
        check("t1_flags",        flags,        4'b0100);
        drain();

        // Back-to-back flag forwarding through the flags register
        send(32'h10, 4'd0, 1'b0, 4'd14, 1'b1, 4'b0000, -1);
        send(32'h11, 4'd1, 1'b1, 4'd14, 1'b1, 4'b0100, -1);
        send(32'h12, 4'd2, 1'b1, 4'd0,  1'b0, 4'b0000, -1);
        check("b2b_B_exec",  out_executed, 1);
        check("b2b_B_wr_en", out_wr_en,    1);
        send(32'h13, 4'd3, 1'b1, 4'd1,  1'b1, 4'b1111, -1);
        check("b2b_C_exec",  out_executed, 0);
        check("b2b_C_wr_en", out_wr_en,    0);
        check("b2b_C_flags", flags,        4'b0100);
        drain();

        // Condition table: set flags with AL, then test the condition
        for (int i = 0; i < 22; i++) begin
            send(32'h5000 + i, 4'd15, 1'b0, 4'd14, 1'b1, vecs[i].nzcv, 1);
            send(32'hA000 + i, i[3:0], 1'b1, vecs[i].cond, 1'b0, 4'b0000, int'(vecs[i].exp_exec));
        end
        drain();

        // Stall: two accepts fill the buffer, third waits
        out_ready = 1'b0;
        send(32'hB1, 4'd1, 1'b1, 4'd14, 1'b0, 4'b0000, -1);
        send(32'hB2, 4'd2, 1'b1, 4'd14, 1'b0, 4'b0000, -1);
        check("stall_in_ready", in_ready, 0);
        in_valid = 1'b1; in_result = 32'hB3; in_rd = 4'd3;
        tick();
        tick();
        check("stall_hold_result", out_result, 32'hB1);
        out_ready = 1'b1;
        send(32'hB3, 4'd3, 1'b1, 4'd14, 1'b0, 4'b0000, -1);
        drain();

        // Flush in TWO with a valid input present
        out_ready = 1'b0;
        send(32'hF1, 4'd1, 1'b1, 4'd14, 1'b1, 4'b1010, -1);
        send(32'hF2, 4'd2, 1'b1, 4'd14, 1'b1, 4'b0011, -1);
        in_valid = 1'b1; in_result = 32'hF3; in_rd = 4'd3; in_cond = 4'd14;
        in_set_flags = 1'b1; {in_n, in_z, in_c, in_v} = 4'b1111;
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_flags",     flags,     4'b0011);
        out_ready = 1'b1;
        tick(); tick(); tick();

        // Asynchronous reset while in ONE
        out_ready = 1'b0;
        send(32'hC0DE, 4'd9, 1'b1, 4'd14, 1'b1, 4'b1100, -1);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid",    out_valid,    0);
        check("arst_in_ready",     in_ready,     0);
        check("arst_out_result",   out_result,   0);
        check("arst_out_rd",       out_rd,       0);
        check("arst_out_wr_en",    out_wr_en,    0);
        check("arst_out_executed", out_executed, 0);
        check("arst_flags",        flags,        0);
        sb.delete();
        mflags = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_release_in_ready", in_ready, 1);
        @(negedge clk);

        // Full throughput with out_ready held high
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send($urandom, i[3:0], i[0], 4'd14, 1'b0, 4'b0000, -1);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_cond_stage.md
# exec_cond_stage

Execute-stage output buffer that sits directly downstream of the ALU and consumes its 32-bit result and N/Z/C/V flags. It holds the architectural NZCV flags register and evaluates each instruction's 4-bit condition code against it. It gates the register write and flag update on that condition. Results pass to writeback through a 2-entry valid/ready skid buffer, so a writeback stall never drops an ALU result.

## Interface
- DATA_W, 32, result width
- RD_W, 4, destination register index width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  ALU result present
- in_ready  out  1  stage can accept
- in_result  in  DATA_W  ALU Result
- in_n, in_z, in_c, in_v  in  1 each  ALU Negative/Zero/Carry/Overflow
- in_cond  in  4  condition code
- in_set_flags  in  1  update flags if executed
- in_rd  in  RD_W  destination register
- in_wr_en  in  1  instruction writes rd
- flush  in  1  discard buffered and incoming entries
- out_valid  out  1  entry to writeback
- out_ready  in  1  writeback accepts
- out_result  out  DATA_W
- out_rd  out  RD_W
- out_wr_en  out  1  in_wr_en AND executed
- out_executed  out  1  condition passed
- flags  out  4  committed {N,Z,C,V}

## Operation
- Accept = in_valid & in_ready & !flush.
- On accept, cond is evaluated against the current flags register value, before this instruction's own update:
  - 0 EQ: Z. 1 NE: !Z. 2 CS: C. 3 CC: !C.
  - 4 MI: N. 5 PL: !N. 6 VS: V. 7 VC: !V.
  - 8 HI: C&!Z. 9 LS: !C|Z. 10 GE: N==V. 11 LT: N!=V.
  - 12 GT: !Z&(N==V). 13 LE: Z|(N!=V). 14 AL: 1. 15 NV: 0.
- Executed & in_set_flags: the flags register loads {in_n,in_z,in_c,in_v} at the accept edge. Back-to-back instructions therefore see the preceding instruction's flags.
- Not executed: flags are unchanged and out_wr_en=0. The entry is still buffered and emitted with out_executed=0, so instruction order and count are preserved.
- Buffer states:
  - EMPTY: no entries.
  - ONE: the output register holds an entry.
  - TWO: output and skid registers both hold entries.
- Transitions (acc = accept, pop = out_valid & out_ready):
  - EMPTY, acc → ONE.
  - ONE, acc & !pop → TWO.
  - ONE, pop & !acc → EMPTY.
  - ONE, acc & pop → ONE, with the output register reloaded.
  - TWO, pop → ONE, with the skid register moved to the output.
  - Otherwise hold.
- in_ready = !rst & (state != TWO); it depends only on the state register.
- out_* = output register contents; out_valid = (state != EMPTY).
- Flush has priority over everything except rst. Next state is EMPTY and no entry is accepted. Any pop in the same cycle completes normally downstream. Flags already committed are NOT rolled back.

## Timing
- Latency: one cycle from accept to out_valid when EMPTY.
- Throughput: one entry per cycle with out_ready held high.
- Output entry and out_valid stay stable while out_valid & !out_ready.
- rst asynchronously forces:
  - state EMPTY, out_valid 0, in_ready 0;
  - out_result 0, out_rd 0, out_wr_en 0, out_executed 0, flags 4'b0000.
- in_ready is 1 in the first cycle after rst deasserts.
- rst mid-stream: all entries are lost and flags are cleared.
- Accept while TWO is impossible because in_ready=0.
- Flags from a flushed instruction remain if it was accepted in an earlier cycle.

## Structure
- Shared package `exec_pkg`:
  - cond code constants (COND_EQ…COND_NV);
  - flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0);
  - buffer state enum (EMPTY, ONE, TWO);
  - entry struct {result, rd, wr_en, executed}.
- Sub-module `cond_eval`: purely combinational, (cond, flags) → pass. It is reused later for conditional branches.

## Test plan
- Reset, then flags=0000, accept cond=14, set_flags=1, in_result=0, Z=1. Required: out_valid next cycle with out_executed=1 and out_wr_en=in_wr_en; flags=0100.
- Back-to-back: instruction A sets Z=1; the next cycle, B with cond=0 (EQ) and wr_en=1, then C with cond=1 (NE). Required: B executed=1, wr_en=1; C executed=0, wr_en=0, flags unchanged.
- Stall: hold out_ready=0 and drive three valid inputs. Required: in_ready drops to 0 after two accepts. Release out_ready: entries emerge in order with no loss and no duplicates.
- Signed condition: flags N=1, V=0 with cond=11 (LT) → executed=1. With cond=12 (GT) → executed=0. cond=15 → executed=0 for any flags.
- Flush in state TWO with in_valid=1. Required: next cycle out_valid=0, state EMPTY, flags keep their last committed value, and the input is not accepted.
- Assert rst asynchronously mid-stream in state ONE. Required: all outputs 0 immediately, before the next clk edge.
